// File: rtl/cpu_pkg.sv
// cpu_pkg: shared decode/execute constants, default field widths, the
// ID->EX payload record and the pipeline-register state encoding.
//   EXE_NOP_OP / EXE_RES_NOP / NOPRegAddr / ZeroWord : NOP field values
//   id_ex_payload_t : packed payload, MSB-first field order used everywhere
//   nop_payload()   : payload presented to EX for a bubble
package cpu_pkg;

    localparam int DATA_W_DEF    = 32;
    localparam int REGADDR_W_DEF = 5;
    localparam int ALUOP_W_DEF   = 8;
    localparam int ALUSEL_W_DEF  = 3;

    localparam logic [ALUOP_W_DEF-1:0]   EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [ALUSEL_W_DEF-1:0]  EXE_RES_NOP = 3'b000;
    localparam logic [REGADDR_W_DEF-1:0] NOPRegAddr  = 5'b00000;
    localparam logic [DATA_W_DEF-1:0]    ZeroWord    = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [ALUOP_W_DEF-1:0]   aluop;
        logic [ALUSEL_W_DEF-1:0]  alusel;
        logic [DATA_W_DEF-1:0]    reg1;
        logic [DATA_W_DEF-1:0]    reg2;
        logic [REGADDR_W_DEF-1:0] wd;
        logic                     wreg;
        logic [DATA_W_DEF-1:0]    link_addr;
        logic                     in_delayslot;
    } id_ex_payload_t;

    function automatic id_ex_payload_t nop_payload();
        id_ex_payload_t p;
        p.aluop        = EXE_NOP_OP;
        p.alusel       = EXE_RES_NOP;
        p.reg1         = ZeroWord;
        p.reg2         = ZeroWord;
        p.wd           = NOPRegAddr;
        p.wreg         = 1'b0;
        p.link_addr    = ZeroWord;
        p.in_delayslot = 1'b0;
        return p;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// pipe_skid_buf: generic valid/ready register slice over a W-bit bus.
// SKID_EN=1: main + skid entry, in_ready registered (state != SKID).
// SKID_EN=0: single entry, in_ready = out_ready | ~out_valid.
// Empty entries always hold FILL, so out_data is FILL whenever out_valid=0.
// Ports: clk, rst (async high), flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data.
module pipe_skid_buf
    import cpu_pkg::*;
#(
    parameter int           W       = 8,
    parameter bit           SKID_EN = 1'b1,
    parameter logic [W-1:0] FILL    = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    pipe_state_e  state, state_n;
    logic [W-1:0] m, m_n;
    logic [W-1:0] s, s_n;
    logic         in_fire, out_fire;

    assign out_valid = (state != ST_EMPTY);
    assign out_data  = m;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    generate
        if (SKID_EN) begin : g_skid
            assign in_ready = (state != ST_SKID);
        end else begin : g_noskid
            assign in_ready = out_ready | ~out_valid;
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
            m     <= FILL;
            s     <= FILL;
        end else begin
            state <= state_n;
            m     <= m_n;
            s     <= s_n;
        end
    end

    always_comb begin
        state_n = state;
        m_n     = m;
        s_n     = s;
        if (flush) begin
            // A same-cycle OUT has already been taken by EX; only held and
            // incoming entries are dropped.
            state_n = ST_EMPTY;
            m_n     = FILL;
            s_n     = FILL;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_n = ST_FULL;
                        m_n     = in_data;
                    end
                end
                ST_FULL: begin
                    if (in_fire && out_fire) begin
                        m_n = in_data;
                    end else if (in_fire && SKID_EN) begin
                        state_n = ST_SKID;
                        s_n     = in_data;
                    end else if (out_fire) begin
                        state_n = ST_EMPTY;
                        m_n     = FILL;
                    end
                end
                ST_SKID: begin
                    // Older entry sits in M, so S only moves up once M leaves.
                    if (out_fire) begin
                        state_n = ST_FULL;
                        m_n     = s;
                        s_n     = FILL;
                    end
                end
                default: begin
                    state_n = ST_EMPTY;
                    m_n     = FILL;
                    s_n     = FILL;
                end
            endcase
        end
    end

endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID->EX pipeline register with valid/ready handshake, optional
// 2-entry skid, flush and delay-slot feedback.
// Ports: clk, rst (async high), flush; id_valid/id_ready + id_* payload;
//        id_next_in_delayslot -> id_is_in_delayslot (registered feedback);
//        ex_valid/ex_ready + ex_* payload (NOP values while ex_valid=0).
module id_ex_pipe
    import cpu_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int REGADDR_W = REGADDR_W_DEF,
    parameter int ALUOP_W   = ALUOP_W_DEF,
    parameter int ALUSEL_W  = ALUSEL_W_DEF,
    parameter bit SKID_EN   = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 id_valid,
    output logic                 id_ready,
    input  logic [ALUOP_W-1:0]   id_aluop,
    input  logic [ALUSEL_W-1:0]  id_alusel,
    input  logic [DATA_W-1:0]    id_reg1,
    input  logic [DATA_W-1:0]    id_reg2,
    input  logic [REGADDR_W-1:0] id_wd,
    input  logic                 id_wreg,
    input  logic [DATA_W-1:0]    id_link_addr,
    input  logic                 id_in_delayslot,
    input  logic                 id_next_in_delayslot,
    output logic                 id_is_in_delayslot,
    output logic                 ex_valid,
    input  logic                 ex_ready,
    output logic [ALUOP_W-1:0]   ex_aluop,
    output logic [ALUSEL_W-1:0]  ex_alusel,
    output logic [DATA_W-1:0]    ex_reg1,
    output logic [DATA_W-1:0]    ex_reg2,
    output logic [REGADDR_W-1:0] ex_wd,
    output logic                 ex_wreg,
    output logic [DATA_W-1:0]    ex_link_addr,
    output logic                 ex_in_delayslot
);

    localparam int PW = ALUOP_W + ALUSEL_W + 3 * DATA_W + REGADDR_W + 2;

    localparam logic [PW-1:0] NOP_FILL = {
        ALUOP_W'(EXE_NOP_OP), ALUSEL_W'(EXE_RES_NOP),
        DATA_W'(ZeroWord), DATA_W'(ZeroWord),
        REGADDR_W'(NOPRegAddr), 1'b0,
        DATA_W'(ZeroWord), 1'b0
    };

    logic [PW-1:0] id_bus, ex_bus;

    assign id_bus = {id_aluop, id_alusel, id_reg1, id_reg2,
                     id_wd, id_wreg, id_link_addr, id_in_delayslot};

    assign {ex_aluop, ex_alusel, ex_reg1, ex_reg2,
            ex_wd, ex_wreg, ex_link_addr, ex_in_delayslot} = ex_bus;

    pipe_skid_buf #(
        .W       (PW),
        .SKID_EN (SKID_EN),
        .FILL    (NOP_FILL)
    ) u_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (id_valid),
        .in_ready  (id_ready),
        .in_data   (id_bus),
        .out_valid (ex_valid),
        .out_ready (ex_ready),
        .out_data  (ex_bus)
    );

    // Tracks whether the next instruction ID issues sits in a delay slot;
    // only advances when ID actually hands an instruction over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_is_in_delayslot <= 1'b0;
        end else if (flush) begin
            id_is_in_delayslot <= 1'b0;
        end else if (id_valid && id_ready) begin
            id_is_in_delayslot <= id_next_in_delayslot;
        end
    end

endmodule

// File: tb/tb_id_ex_pipe.sv
module tb_id_ex_pipe;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        id_valid, id_ready;
    logic        id_next_in_delayslot, id_is_in_delayslot;
    logic        ex_valid, ex_ready;
    id_ex_payload_t pin, ex_p, z_p;

    logic [7:0]  ex_aluop, z_aluop;
    logic [2:0]  ex_alusel, z_alusel;
    logic [31:0] ex_reg1, ex_reg2, ex_link_addr, z_reg1, z_reg2, z_link_addr;
    logic [4:0]  ex_wd, z_wd;
    logic        ex_wreg, ex_in_delayslot, z_wreg, z_in_delayslot;
    logic        z_id_valid, z_id_ready, z_ex_valid, z_ex_ready, z_ds;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    assign ex_p = {ex_aluop, ex_alusel, ex_reg1, ex_reg2, ex_wd, ex_wreg, ex_link_addr, ex_in_delayslot};
    assign z_p  = {z_aluop, z_alusel, z_reg1, z_reg2, z_wd, z_wreg, z_link_addr, z_in_delayslot};

    id_ex_pipe #(.SKID_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(id_valid), .id_ready(id_ready),
        .id_aluop(pin.aluop), .id_alusel(pin.alusel),
        .id_reg1(pin.reg1), .id_reg2(pin.reg2),
        .id_wd(pin.wd), .id_wreg(pin.wreg),
        .id_link_addr(pin.link_addr), .id_in_delayslot(pin.in_delayslot),
        .id_next_in_delayslot(id_next_in_delayslot), .id_is_in_delayslot(id_is_in_delayslot),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_aluop(ex_aluop), .ex_alusel(ex_alusel),
        .ex_reg1(ex_reg1), .ex_reg2(ex_reg2),
        .ex_wd(ex_wd), .ex_wreg(ex_wreg),
        .ex_link_addr(ex_link_addr), .ex_in_delayslot(ex_in_delayslot)
    );

    id_ex_pipe #(.SKID_EN(1'b0)) dut0 (
        .clk(clk), .rst(rst), .flush(flush),
        .id_valid(z_id_valid), .id_ready(z_id_ready),
        .id_aluop(pin.aluop), .id_alusel(pin.alusel),
        .id_reg1(pin.reg1), .id_reg2(pin.reg2),
        .id_wd(pin.wd), .id_wreg(pin.wreg),
        .id_link_addr(pin.link_addr), .id_in_delayslot(pin.in_delayslot),
        .id_next_in_delayslot(id_next_in_delayslot), .id_is_in_delayslot(z_ds),
        .ex_valid(z_ex_valid), .ex_ready(z_ex_ready),
        .ex_aluop(z_aluop), .ex_alusel(z_alusel),
        .ex_reg1(z_reg1), .ex_reg2(z_reg2),
        .ex_wd(z_wd), .ex_wreg(z_wreg),
        .ex_link_addr(z_link_addr), .ex_in_delayslot(z_in_delayslot)
    );

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        fl;
        logic        v;
        logic [31:0] r1;
        logic        nds;
        logic        rdy;
        logic        e_v;
        logic [31:0] e_r1;
        logic        e_rdy;
        logic        e_ds;
    } vec_t;

    vec_t tbl[16];

    // Reference model: ordered queue of accepted payloads, capacity two.
    id_ex_payload_t q[$];
    logic           m_ds;

    initial begin
        rst = 1'b1; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b0;
        id_next_in_delayslot = 1'b0; z_id_valid = 1'b0; z_ex_ready = 1'b0;
        pin = nop_payload();
        #1;
        check("reset_ex_valid", ex_valid, 0);
        check("reset_id_ready", id_ready, 1);
        check("reset_payload_nop", ex_p, nop_payload());
        check("reset_ds", id_is_in_delayslot, 0);
        step(); step();
        rst = 1'b0;

        //          fl v  reg1        nds rdy  e_v e_r1       e_rdy e_ds
        tbl[0]  = '{0, 1, 32'h1,      0,  1,   1,  32'h1,     1,    0};
        tbl[1]  = '{0, 1, 32'h2,      0,  1,   1,  32'h2,     1,    0};
        tbl[2]  = '{0, 1, 32'h3,      0,  1,   1,  32'h3,     1,    0};
        tbl[3]  = '{0, 0, 32'h0,      0,  1,   0,  32'h0,     1,    0};
        tbl[4]  = '{0, 1, 32'hA,      0,  0,   1,  32'hA,     1,    0};
        tbl[5]  = '{0, 1, 32'hB,      0,  0,   1,  32'hA,     0,    0};
        tbl[6]  = '{0, 1, 32'hC,      0,  0,   1,  32'hA,     0,    0};
        tbl[7]  = '{0, 0, 32'h0,      0,  1,   1,  32'hB,     1,    0};
        tbl[8]  = '{0, 0, 32'h0,      0,  1,   0,  32'h0,     1,    0};
        tbl[9]  = '{0, 1, 32'hD,      0,  0,   1,  32'hD,     1,    0};
        tbl[10] = '{0, 1, 32'hE,      0,  0,   1,  32'hD,     0,    0};
        tbl[11] = '{1, 1, 32'hF,      0,  0,   0,  32'h0,     1,    0};
        tbl[12] = '{0, 0, 32'h0,      0,  1,   0,  32'h0,     1,    0};
        tbl[13] = '{0, 1, 32'h7,      1,  1,   1,  32'h7,     1,    1};
        tbl[14] = '{0, 0, 32'h0,      0,  0,   1,  32'h7,     1,    1};
        tbl[15] = '{1, 0, 32'h0,      0,  0,   0,  32'h0,     1,    0};

        for (int i = 0; i < 16; i++) begin
            flush = tbl[i].fl; id_valid = tbl[i].v; ex_ready = tbl[i].rdy;
            id_next_in_delayslot = tbl[i].nds;
            pin = nop_payload(); pin.reg1 = tbl[i].r1;
            step();
            check($sformatf("vec%0d_ex_valid", i), ex_valid, tbl[i].e_v);
            check($sformatf("vec%0d_ex_reg1", i), ex_reg1, tbl[i].e_r1);
            check($sformatf("vec%0d_id_ready", i), id_ready, tbl[i].e_rdy);
            check($sformatf("vec%0d_ds", i), id_is_in_delayslot, tbl[i].e_ds);
        end

        // Randomized phase against the queue model (starts empty, ds=0).
        q.delete(); m_ds = 1'b0;
        for (int c = 0; c < 400; c++) begin
            int  sz;
            bit  in_f, out_f;
            id_ex_payload_t exp_p;
            flush    = ($urandom_range(0, 19) == 0);
            id_valid = ($urandom_range(0, 9) < 7);
            ex_ready = ($urandom_range(0, 9) < 6);
            id_next_in_delayslot = $urandom_range(0, 1);
            pin = {$urandom, $urandom, $urandom, $urandom};
            sz    = q.size();
            in_f  = id_valid && (sz < 2);
            out_f = ex_ready && (sz > 0);
            step();
            if (flush) begin
                q.delete(); m_ds = 1'b0;
            end else begin
                if (out_f) void'(q.pop_front());
                if (in_f) begin
                    q.push_back(pin);
                    m_ds = id_next_in_delayslot;
                end
            end
            exp_p = (q.size() > 0) ? q[0] : nop_payload();
            check("rand_ex_valid", ex_valid, q.size() > 0);
            check("rand_id_ready", id_ready, q.size() < 2);
            check("rand_payload", ex_p, exp_p);
            check("rand_ds", id_is_in_delayslot, m_ds);
        end

        // Reset mid-stream with both entries occupied: takes effect without a clock edge.
        flush = 1'b0; ex_ready = 1'b0; id_valid = 1'b1;
        pin = nop_payload(); pin.aluop = 8'h55; pin.wd = 5'd9; pin.reg1 = 32'h1234;
        step(); step();
        check("pre_reset_skid_id_ready", id_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midreset_ex_valid", ex_valid, 0);
        check("midreset_id_ready", id_ready, 1);
        check("midreset_aluop", ex_aluop, EXE_NOP_OP);
        check("midreset_wd", ex_wd, 0);
        id_valid = 1'b0;
        step();
        rst = 1'b0;

        // Single-entry variant: combinational id_ready and 1/cycle replacement.
        z_id_valid = 1'b1; z_ex_ready = 1'b0; pin = nop_payload(); pin.reg1 = 32'h5;
        step();
        check("noskid_full_valid", z_ex_valid, 1);
        check("noskid_full_reg1", z_reg1, 32'h5);
        check("noskid_blocked_ready", z_id_ready, 0);
        z_ex_ready = 1'b1;
        #1;
        check("noskid_comb_ready", z_id_ready, 1);
        pin.reg1 = 32'h6;
        step();
        check("noskid_stream6", z_reg1, 32'h6);
        pin.reg1 = 32'h7;
        step();
        check("noskid_stream7", z_reg1, 32'h7);
        check("noskid_stream_valid", z_ex_valid, 1);
        z_id_valid = 1'b0;
        step();
        check("noskid_drain_valid", z_ex_valid, 0);
        check("noskid_drain_nop", z_p, nop_payload());

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
